// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle single-bit shift sequencer with shift-register control word
//
// Purpose:
//   Accepts one LSL/LSR (optionally ASR) request, loads the operand and shifts
//   it one bit per clock until the clamped shift amount is used up. Every cycle
//   it also drives the control word for an external N-bit shift register, so
//   that register tracks the internal result register in lockstep.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request strobe, only looked at while busy = 0
//   op                00 LSL, 01 LSR, 10 ASR (optional), 11 reserved
//   shamt, operand    shift amount and data, captured with an accepted start
//   busy              high from acceptance until the operation retires
//   done              one-cycle completion pulse, result valid in that cycle
//   result            internal register, changes only on a load or a shift
//   sr_enable         external shift register enable
//   sr_mode           00 load, 01 shift right, 10 shift left, 11 clear
//   sr_loadin         load data for the external register
//   sr_left_in        MSB fill for a right shift
//   sr_right_in       LSB fill for a left shift
//
// Configuration:
//   SHIFT_SEQ_ASR_EN  when defined, op 10 is an arithmetic right shift; when
//                     undefined, op 10 is ignored like op 11 and no sign-fill
//                     logic exists.

module shift_sequencer #(
   parameter int N  = 64,
   parameter int SW = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [SW-1:0] shamt,
   input  logic [N-1:0]  operand,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  result,
   output logic          sr_enable,
   output logic [1:0]    sr_mode,
   output logic [N-1:0]  sr_loadin,
   output logic          sr_left_in,
   output logic          sr_right_in
);

   localparam logic [1:0] OP_LSL    = 2'b00;
   localparam logic [1:0] OP_LSR    = 2'b01;
`ifdef SHIFT_SEQ_ASR_EN
   localparam logic [1:0] OP_ASR    = 2'b10;
`endif

   localparam logic [1:0] MODE_LOAD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_CLR  = 2'b11;

   localparam logic [SW-1:0] N_SW   = SW'(N);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t        state;
   logic [1:0]    op_q;
   logic [SW-1:0] count;
   // Set by reset so the first cycle out of reset clears the downstream register.
   logic          clr_pend;

   logic          op_legal;
   logic          accept;
   logic          step;
   logic [SW-1:0] shamt_clamped;
   logic          fill_msb;
   logic [N-1:0]  shifted;

   // Request decode
   always_comb begin
      op_legal = (op == OP_LSL) || (op == OP_LSR);
`ifdef SHIFT_SEQ_ASR_EN
      op_legal = op_legal || (op == OP_ASR);
`endif
   end

   assign accept        = (state == S_IDLE) && start && op_legal;
   assign step          = (state == S_SHIFT) && (count != '0);
   // Amounts of N or more all produce exactly N single-bit steps.
   assign shamt_clamped = (shamt >= N_SW) ? N_SW : shamt;

   // Fill bit entering at the MSB on a right shift
`ifdef SHIFT_SEQ_ASR_EN
   assign fill_msb = (op_q == OP_ASR) ? result[N-1] : 1'b0;
`else
   assign fill_msb = 1'b0;
`endif

   // Next value of the internal register for one step
   always_comb begin
      if (op_q == OP_LSL) begin
         shifted = {result[N-2:0], 1'b0};
      end else begin
         shifted = {fill_msb, result[N-1:1]};
      end
   end

   // External shift-register control word. The load is driven in the accepting
   // cycle itself so the external register captures the operand on the same
   // edge as the internal one. A start in the post-reset cycle wins over the
   // clear, since the load overwrites the register anyway.
   always_comb begin
      sr_enable   = 1'b0;
      sr_mode     = MODE_LOAD;
      sr_loadin   = '0;
      sr_left_in  = 1'b0;
      sr_right_in = 1'b0;
      if (accept) begin
         sr_enable = 1'b1;
         sr_mode   = MODE_LOAD;
         sr_loadin = operand;
      end else if (step) begin
         sr_enable  = 1'b1;
         sr_mode    = (op_q == OP_LSL) ? MODE_SHL : MODE_SHR;
         sr_left_in = fill_msb;
      end else if (clr_pend) begin
         sr_enable = 1'b1;
         sr_mode   = MODE_CLR;
      end
   end

   // Sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         count    <= '0;
         op_q     <= OP_LSL;
         clr_pend <= 1'b1;
      end else begin
         done     <= 1'b0;
         clr_pend <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  result <= operand;
                  count  <= shamt_clamped;
                  op_q   <= op;
                  busy   <= 1'b1;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (count != '0) begin
                  result <= shifted;
                  count  <= count - SW'(1);
               end else begin
                  // Retire: the following cycle is an IDLE cycle carrying done.
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer (64-bit and 8-bit instances)

module tb_shift_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        s64;
   logic [1:0]  op64;
   logic [6:0]  sh64;
   logic [63:0] opd64;
   logic        busy64, done64, en64, li64, ri64;
   logic [1:0]  mode64;
   logic [63:0] res64, ld64;

   logic        s8;
   logic [1:0]  op8;
   logic [3:0]  sh8;
   logic [7:0]  opd8;
   logic        busy8, done8, en8, li8, ri8;
   logic [1:0]  mode8;
   logic [7:0]  res8, ld8;

   int checks = 0;
   int errors = 0;
   int lat;
   logic seen;

   shift_sequencer #(.N(64), .SW(7)) dut64 (
      .clk(clk), .reset(reset), .start(s64), .op(op64), .shamt(sh64), .operand(opd64),
      .busy(busy64), .done(done64), .result(res64), .sr_enable(en64), .sr_mode(mode64),
      .sr_loadin(ld64), .sr_left_in(li64), .sr_right_in(ri64)
   );

   shift_sequencer #(.N(8), .SW(4)) dut8 (
      .clk(clk), .reset(reset), .start(s8), .op(op8), .shamt(sh8), .operand(opd8),
      .busy(busy8), .done(done8), .result(res8), .sr_enable(en8), .sr_mode(mode8),
      .sr_loadin(ld8), .sr_left_in(li8), .sr_right_in(ri8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request; lat = edges from the accepting edge to the edge that raises done.
   task automatic go64(input logic [1:0] op, input logic [63:0] opd, input logic [6:0] sh,
                       output int l);
      @(negedge clk); s64 = 1'b1; op64 = op; opd64 = opd; sh64 = sh; #1;
      chk("go64_load_en", en64, 1);
      chk("go64_load_mode", mode64, 0);
      l = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); s64 = 1'b0; #1;
         if (done64) begin l = i; break; end
      end
   endtask

   task automatic go8(input logic [1:0] op, input logic [7:0] opd, input logic [3:0] sh,
                      output int l);
      @(negedge clk); s8 = 1'b1; op8 = op; opd8 = opd; sh8 = sh; #1;
      chk("go8_load_en", en8, 1);
      chk("go8_load_data", ld8, opd);
      l = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); s8 = 1'b0; #1;
         if (done8) begin l = i; break; end
      end
   endtask

   initial begin
      reset = 1'b1;
      s64 = 1'b0; op64 = 2'b00; sh64 = '0; opd64 = '0;
      s8  = 1'b0; op8  = 2'b00; sh8  = '0; opd8  = '0;
      @(negedge clk);
      @(negedge clk); reset = 1'b0; #1;

      // Post-reset cycle: idle, clear issued downstream
      chk("rst_busy", busy64, 0);
      chk("rst_done", done64, 0);
      chk("rst_result", res64, 0);
      chk("rst_en", en64, 1);
      chk("rst_mode", mode64, 2'b11);
      chk("rst_loadin", ld64, 0);
      chk("rst_fill", {li64, ri64}, 0);
      chk("rst8_mode", {en8, mode8}, 3'b111);

      @(negedge clk); #1;
      chk("idle_hold_en", en64, 0);

      // LSL 0x1 by 4: modes 00,10,10,10,10 then hold, done after 5 edges
      @(negedge clk); s64 = 1'b1; op64 = 2'b00; opd64 = 64'h1; sh64 = 7'd4; #1;
      chk("lsl_acc_en", en64, 1);
      chk("lsl_acc_mode", mode64, 2'b00);
      chk("lsl_acc_loadin", ld64, 64'h1);
      chk("lsl_acc_busy", busy64, 0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); s64 = 1'b0; #1;
         chk("lsl_step_en", en64, 1);
         chk("lsl_step_mode", mode64, 2'b10);
         chk("lsl_step_fill", ri64, 0);
         chk("lsl_step_busy", busy64, 1);
      end
      @(negedge clk); #1;
      chk("lsl_last_en", en64, 0);
      chk("lsl_last_busy", busy64, 1);
      chk("lsl_last_result", res64, 64'h10);
      @(negedge clk); #1;
      chk("lsl_done", done64, 1);
      chk("lsl_done_busy", busy64, 0);
      chk("lsl_result", res64, 64'h10);
      @(negedge clk); #1;
      chk("lsl_done_pulse", done64, 0);
      chk("lsl_result_held", res64, 64'h10);

      // LSR MSB by 63
      go64(2'b01, 64'h8000_0000_0000_0000, 7'd63, lat);
      chk("lsr63_latency", lat, 64);
      chk("lsr63_result", res64, 64'h1);

      // LSR by 100 on the 64-bit instance clamps to 64 shifts
      go64(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 7'd100, lat);
      chk("lsr_clamp64_latency", lat, 65);
      chk("lsr_clamp64_result", res64, 64'h0);

      // Reserved op ignored
      @(negedge clk); s64 = 1'b1; op64 = 2'b11; opd64 = 64'h1234; sh64 = 7'd1; #1;
      chk("op11_no_load", en64, 0);
      @(negedge clk); s64 = 1'b0; #1;
      chk("op11_busy", busy64, 0);
      chk("op11_result", res64, 64'h0);

      // N=8 LSR 0xFF by 12: clamp to 8
      go8(2'b01, 8'hFF, 4'd12, lat);
      chk("clamp8_latency", lat, 9);
      chk("clamp8_result", res8, 8'h00);

      // shamt 0, then back-to-back start in the done cycle, then start during busy
      go8(2'b00, 8'hA5, 4'd0, lat);
      chk("zero_latency", lat, 1);
      chk("zero_result", res8, 8'hA5);
      chk("zero_busy", busy8, 0);
      s8 = 1'b1; op8 = 2'b00; opd8 = 8'h03; sh8 = 4'd2; #1;
      chk("b2b_done_still", done8, 1);
      chk("b2b_acc_en", en8, 1);
      chk("b2b_acc_mode", mode8, 2'b00);
      chk("b2b_acc_loadin", ld8, 8'h03);
      @(negedge clk); s8 = 1'b1; op8 = 2'b01; opd8 = 8'hFF; sh8 = 4'd1; #1;
      chk("busy_start_busy", busy8, 1);
      chk("busy_start_mode", mode8, 2'b10);
      chk("busy_start_loadin", ld8, 8'h00);
      // Second request retires two edges after this cycle
      lat = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); s8 = 1'b0; #1;
         if (done8) begin lat = i; break; end
      end
      chk("b2b_latency", lat, 2);
      chk("b2b_result", res8, 8'h0C);

`ifdef SHIFT_SEQ_ASR_EN
      go8(2'b10, 8'h90, 4'd3, lat);
      chk("asr_latency", lat, 4);
      chk("asr_result", res8, 8'hF2);
      go8(2'b10, 8'h80, 4'd9, lat);
      chk("asr_clamp_result", res8, 8'hFF);
`else
      @(negedge clk); s8 = 1'b1; op8 = 2'b10; opd8 = 8'h90; sh8 = 4'd3; #1;
      chk("asr_off_no_load", en8, 0);
      @(negedge clk); s8 = 1'b0; #1;
      chk("asr_off_busy", busy8, 0);
      @(negedge clk); #1;
      chk("asr_off_busy2", busy8, 0);
      chk("asr_off_result", res8, 8'h0C);
`endif

      // Reset after 2 of 5 shifts
      @(negedge clk); s64 = 1'b1; op64 = 2'b00; opd64 = 64'h1; sh64 = 7'd5; #1;
      @(negedge clk); s64 = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("mid_result", res64, 64'h4);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0; #1;
      chk("abort_busy", busy64, 0);
      chk("abort_result", res64, 0);
      chk("abort_clear", {en64, mode64}, 3'b111);
      chk("abort_done", done64, 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         seen = seen | done64;
      end
      chk("abort_no_done", seen, 0);
      chk("abort_idle_en", en64, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
